// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: turns level-held MEM-stage commands into single req/ack bus transactions with timeout.
// Define DMEM_POSTED_WRITE_EN to add a one-entry posted-write buffer (writes complete before the bus acks).
module dmem_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ReadEnable,
   input  logic [3:0]  WriteEnable,
   input  logic [31:0] Address,
   input  logic [31:0] MWriteData,
   output logic [31:0] MReadData,
   output logic        DataMem_Ready,
   output logic        BusError,
   output logic        DBus_Req,
   output logic [3:0]  DBus_WE,
   output logic [29:0] DBus_Addr,
   output logic [31:0] DBus_WData,
   input  logic        DBus_Ack,
   input  logic [31:0] DBus_RData
);
   localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic          req_n, ready_n, err_n;
   logic [3:0]    we_n;
   logic [29:0]   addr_n;
   logic [31:0]   wdata_n, rdata_n;
   logic          cmd, is_write, timeout_hit;
   logic          unused_addr;
`ifdef DMEM_POSTED_WRITE_EN
   logic          posted, posted_n;
`endif

   assign unused_addr = ^Address[1:0];
   assign is_write    = (WriteEnable != 4'b0000);
   assign cmd         = ReadEnable | is_write;
   // Saturating: the counter parks at the terminal count instead of wrapping.
   assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      req_n   = DBus_Req;
      we_n    = DBus_WE;
      addr_n  = DBus_Addr;
      wdata_n = DBus_WData;
      rdata_n = MReadData;
      ready_n = 1'b0;
      err_n   = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
      posted_n = posted;
`endif
      case (state)
         IDLE: begin
            if (cmd) begin
               state_n = BUS;
               cnt_n   = '0;
               req_n   = 1'b1;
               we_n    = WriteEnable;
               addr_n  = Address[31:2];
               wdata_n = MWriteData;
`ifdef DMEM_POSTED_WRITE_EN
               // Posted write completes toward the controller now; the bus drains it in the background.
               if (is_write) begin
                  posted_n = 1'b1;
                  ready_n  = 1'b1;
                  rdata_n  = '0;
               end
`endif
            end
         end
         BUS: begin
            if (DBus_Ack) begin
               req_n = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
               if (posted) begin
                  posted_n = 1'b0;
                  state_n  = IDLE;
               end else begin
                  state_n = RESP;
                  ready_n = 1'b1;
                  rdata_n = (DBus_WE == 4'b0000) ? DBus_RData : '0;
               end
`else
               state_n = RESP;
               ready_n = 1'b1;
               rdata_n = (DBus_WE == 4'b0000) ? DBus_RData : '0;
`endif
            end else if (timeout_hit) begin
               req_n = 1'b0;
               cnt_n = cnt_inc;
               err_n = 1'b1;
`ifdef DMEM_POSTED_WRITE_EN
               if (posted) begin
                  posted_n = 1'b0;
                  state_n  = IDLE;
               end else begin
                  state_n = RESP;
                  ready_n = 1'b1;
                  rdata_n = '0;
               end
`else
               state_n = RESP;
               ready_n = 1'b1;
               rdata_n = '0;
`endif
            end else begin
               cnt_n = cnt_inc;
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         DBus_Req      <= 1'b0;
         DBus_WE       <= '0;
         DBus_Addr     <= '0;
         DBus_WData    <= '0;
         MReadData     <= '0;
         DataMem_Ready <= 1'b0;
         BusError      <= 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
         posted        <= 1'b0;
`endif
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         DBus_Req      <= req_n;
         DBus_WE       <= we_n;
         DBus_Addr     <= addr_n;
         DBus_WData    <= wdata_n;
         MReadData     <= rdata_n;
         DataMem_Ready <= ready_n;
         BusError      <= err_n;
`ifdef DMEM_POSTED_WRITE_EN
         posted        <= posted_n;
`endif
      end
   end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: stimulus pushes expected bus ops and responses, monitors pop and compare.
module tb_dmem_bus_bridge;
   localparam int unsigned TO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        ReadEnable;
   logic [3:0]  WriteEnable;
   logic [31:0] Address, MWriteData;
   logic [31:0] MReadData;
   logic        DataMem_Ready, BusError, DBus_Req;
   logic [3:0]  DBus_WE;
   logic [29:0] DBus_Addr;
   logic [31:0] DBus_WData;
   logic        DBus_Ack;
   logic [31:0] DBus_RData;

   dmem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
      .Address(Address), .MWriteData(MWriteData), .MReadData(MReadData),
      .DataMem_Ready(DataMem_Ready), .BusError(BusError), .DBus_Req(DBus_Req),
      .DBus_WE(DBus_WE), .DBus_Addr(DBus_Addr), .DBus_WData(DBus_WData),
      .DBus_Ack(DBus_Ack), .DBus_RData(DBus_RData)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [29:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned ack_k;   // ack in this request cycle; 0 = never ack
      bit          abandon;
   } bus_op_t;

   typedef struct {
      bit          ready;
      bit          err;
      logic [31:0] rdata;
      int          lat;     // -1 = latency not predicted
      int unsigned issue;
   } resp_t;

   bus_op_t     bus_q[$];
   resp_t       resp_q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned edge_cnt = 0;
   bit          force_ack = 1'b0;
   bit          drain_pending = 1'b0;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus slave: verifies each request against the expected op and acks in the scheduled request cycle.
   initial begin : responder
      bus_op_t     op;
      bit          busy;
      int unsigned cyc;
      busy = 1'b0;
      cyc  = 0;
      op   = '{default: 0};
      DBus_Ack   = 1'b0;
      DBus_RData = '0;
      forever begin
         @(negedge clock);
         if (DBus_Req && !busy) begin
            busy = 1'b1;
            cyc  = 1;
            checks++;
            if (bus_q.size() == 0) begin
               failures++;
               $display("FAIL bus_req: request raised with no bus op outstanding (t=%0t)", $time);
               op = '{default: 0};
            end else begin
               op = bus_q.pop_front();
            end
            check("bus_addr", 32'(DBus_Addr), 32'(op.addr));
            check("bus_we", 32'(DBus_WE), 32'(op.we));
            check("bus_wdata", DBus_WData, op.wdata);
         end else if (DBus_Req) begin
            cyc++;
            check("bus_addr_stable", 32'(DBus_Addr), 32'(op.addr));
            check("bus_we_stable", 32'(DBus_WE), 32'(op.we));
         end else if (busy) begin
            busy = 1'b0;
            if (!op.abandon)
               check("req_cycles", cyc, (op.ack_k == 0) ? TO : op.ack_k);
         end
         DBus_Ack   = (busy && op.ack_k != 0 && cyc == op.ack_k) || force_ack;
         DBus_RData = busy ? op.rdata : $urandom;
      end
   end

   initial begin : monitor
      resp_t r;
      forever begin
         @(negedge clock);
         if (DataMem_Ready || BusError) begin
            checks++;
            if (resp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_resp: ready=%0b err=%0b with no response outstanding (t=%0t)",
                        DataMem_Ready, BusError, $time);
            end else begin
               r = resp_q.pop_front();
               check("ready", 32'(DataMem_Ready), 32'(r.ready));
               check("bus_error", 32'(BusError), 32'(r.err));
               if (r.ready) check("rdata", MReadData, r.rdata);
               if (r.lat >= 0) check("latency", edge_cnt - r.issue, 32'(r.lat));
            end
         end
      end
   end

   // Controller model: hold the command until Ready, keep it through the Ready cycle, then drop or chain.
   task automatic run_txn(input bit rd, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int unsigned k, input int unsigned gap);
      bus_op_t op;
      resp_t   r;
      bit      is_wr;
      int      n;
      is_wr      = (we != 4'b0000);
      op.addr    = addr[31:2];
      op.we      = we;
      op.wdata   = wdata;
      op.rdata   = rdata;
      op.ack_k   = k;
      op.abandon = 1'b0;
      bus_q.push_back(op);
      r.issue = edge_cnt;
`ifdef DMEM_POSTED_WRITE_EN
      if (is_wr) begin
         r.ready = 1'b1; r.err = 1'b0; r.rdata = '0;
         r.lat = drain_pending ? -1 : 1;
         resp_q.push_back(r);
         if (k == 0) begin
            r.ready = 1'b0; r.err = 1'b1; r.lat = -1;
            resp_q.push_back(r);
         end
      end else begin
         r.ready = 1'b1; r.err = (k == 0);
         r.rdata = (k == 0) ? 32'h0 : rdata;
         r.lat = drain_pending ? -1 : ((k == 0) ? int'(TO) + 1 : int'(k) + 1);
         resp_q.push_back(r);
      end
      drain_pending = is_wr;
`else
      r.ready = 1'b1; r.err = (k == 0);
      r.rdata = (is_wr || k == 0) ? 32'h0 : rdata;
      r.lat = (k == 0) ? int'(TO) + 1 : int'(k) + 1;
      resp_q.push_back(r);
`endif
      ReadEnable = rd; WriteEnable = we; Address = addr; MWriteData = wdata;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!DataMem_Ready && n < 60);
      checks++;
      if (!DataMem_Ready) begin
         failures++;
         $display("FAIL ready_wait: no DataMem_Ready within 60 cycles for addr 0x%08h", addr);
      end
      @(negedge clock);
      ReadEnable = 1'b0; WriteEnable = '0;
      repeat (gap) @(negedge clock);
   endtask

   initial begin : stimulus
      bus_op_t op;
      bit          rd;
      logic [3:0]  we;
      int unsigned k;
      reset = 1'b1; ReadEnable = 1'b0; WriteEnable = '0; Address = '0; MWriteData = '0;
      repeat (2) @(negedge clock);
      check("rst_rdata", MReadData, 32'h0);
      check("rst_ready", 32'(DataMem_Ready), 32'h0);
      check("rst_err", 32'(BusError), 32'h0);
      check("rst_req", 32'(DBus_Req), 32'h0);
      check("rst_we", 32'(DBus_WE), 32'h0);
      check("rst_addr", 32'(DBus_Addr), 32'h0);
      check("rst_wdata", DBus_WData, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      run_txn(1'b1, 4'b0000, 32'h0000_1004, $urandom, 32'hDEAD_BEEF, 3, 0);
      run_txn(1'b0, 4'b0100, 32'h0000_2008, 32'h5A5A_5A5A, $urandom, 1, 1);
      run_txn(1'b1, 4'b0000, 32'h0000_3000, $urandom, $urandom, 0, 0);
      run_txn(1'b1, 4'b0000, 32'h0000_300C, $urandom, 32'hC0DE_0004, TO, 1);
      run_txn(1'b0, 4'b1111, 32'h0000_0040, 32'h1234_5678, $urandom, 2, 0);
      run_txn(1'b1, 4'b0000, 32'h0000_0040, $urandom, 32'h1234_5678, 1, 2);

      // Reset during a read's bus phase: no completion, late ack ignored.
      op = '{addr: 30'h0000_0123, we: 4'b0000, wdata: 32'h0, rdata: 32'h0, ack_k: 0, abandon: 1'b1};
      bus_q.push_back(op);
      ReadEnable = 1'b1; Address = 32'h0000_048C; MWriteData = 32'h0;
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1 check("async_req_drop", 32'(DBus_Req), 32'h0);
      check("async_ready_low", 32'(DataMem_Ready), 32'h0);
      ReadEnable = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      drain_pending = 1'b0;
      force_ack = 1'b1;
      repeat (2) @(negedge clock);
      force_ack = 1'b0;
      @(negedge clock);
      check("late_ack_req", 32'(DBus_Req), 32'h0);
      check("late_ack_ready", 32'(DataMem_Ready), 32'h0);
      run_txn(1'b1, 4'b0000, 32'h0000_0500, $urandom, 32'hA5A5_0001, 2, 0);

      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom_range(0, 1));
         we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         if (!rd && we == 4'b0000) rd = 1'b1;
         k = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
         run_txn(rd, we, $urandom, $urandom, $urandom, k, $urandom_range(0, 2));
      end

      repeat (12) @(negedge clock);
      check("resp_q_drained", resp_q.size(), 32'h0);
      check("bus_q_drained", bus_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Data-memory bus bridge sitting directly downstream of the MEM-stage memory controller. It accepts the controller's level-held read/write commands (ReadEnable, per-byte WriteEnable, Address, MWriteData) and runs them as single transactions on an external req/ack data bus of arbitrary latency. It returns a one-cycle DataMem_Ready pulse with registered read data, and bounds every transaction with a bus timeout that reports BusError.

## Interface
- TIMEOUT_CYCLES, 256: max cycles DBus_Req may stay high without DBus_Ack; 0 disables the timeout.
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ReadEnable  in  1  read command from controller, held until DataMem_Ready.
- WriteEnable  in  4  byte write enables (bit 3 = bits 31:24), held until DataMem_Ready.
- Address  in  32  byte address; only [31:2] is used.
- MWriteData  in  32  write data, lane-replicated by controller.
- MReadData  out  32  read data to controller, valid in the DataMem_Ready cycle.
- DataMem_Ready  out  1  one-cycle completion pulse.
- BusError  out  1  one-cycle pulse on transaction timeout.
- DBus_Req  out  1  bus request, held until acknowledged or timed out.
- DBus_WE  out  4  byte write enables on bus; 0000 = read.
- DBus_Addr  out  30  word address on bus.
- DBus_WData  out  32  write data on bus.
- DBus_Ack  in  1  bus completion, sampled while DBus_Req = 1.
- DBus_RData  in  32  bus read data, valid in the DBus_Ack cycle.

## Operation
- Command = ReadEnable | (WriteEnable != 0). If both are present, the write wins and the read is ignored.
- FSM states: IDLE, BUS, RESP.
- IDLE -> BUS on command:
  - Capture Address[31:2], WriteEnable (0000 for a read) and MWriteData into DBus_Addr/DBus_WE/DBus_WData.
  - Set DBus_Req.
- BUS:
  - DBus_Req, DBus_Addr, DBus_WE and DBus_WData are stable until exit.
  - On DBus_Ack = 1: clear DBus_Req, register DBus_RData into MReadData (reads only; writes leave it at 0), -> RESP.
- RESP: DataMem_Ready = 1 for exactly this cycle, -> IDLE.
  - Commands are ignored in RESP; the controller still drives them this cycle and drops them on the next cycle.
- Timeout (TIMEOUT_CYCLES > 0):
  - The cycle counter clears on BUS entry and increments each BUS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: clear DBus_Req, MReadData = 0, -> RESP, BusError = 1 in the same cycle as DataMem_Ready.
  - Ack in the same cycle as the terminal count wins; no error is raised.
- Counter width is clog2(TIMEOUT_CYCLES+1) and the counter saturates; it never wraps.
- Outside a completion cycle MReadData holds its last value.

## Timing
- Reset values: MReadData = 0, DataMem_Ready = 0, BusError = 0, DBus_Req = 0, DBus_WE = 0, DBus_Addr = 0, DBus_WData = 0, FSM = IDLE, counter = 0.
- All outputs are registered.
- Command seen at edge N -> DBus_Req high in cycle N+1.
- Ack in cycle N+k (k ≥ 1) -> DataMem_Ready in cycle N+k+1. Minimum round trip is 2 cycles.
- Back-to-back commands: the next command is accepted no earlier than the cycle after RESP.
- Timeout: DataMem_Ready and BusError assert together in the cycle after the counter reaches TIMEOUT_CYCLES.
- Reset mid-transaction:
  - DBus_Req drops asynchronously.
  - The transaction is abandoned and no DataMem_Ready is issued.
  - A late DBus_Ack after reset is ignored in IDLE.

## Configuration
- DMEM_POSTED_WRITE_EN defined adds a one-entry posted-write buffer:
  - Accept: a write seen in IDLE with the buffer empty is captured into the buffer. DataMem_Ready pulses the next cycle (latency 1). The buffer then drains on the bus in the background using the BUS rules.
  - Blocked commands: any command arriving while the buffer is non-empty (read or write) waits until the drain completes. It is then accepted normally, which preserves ordering.
  - Drain timeout: BusError pulses alone, without DataMem_Ready, and the buffered write is dropped.
- DMEM_POSTED_WRITE_EN undefined: writes use the blocking BUS path exactly like reads, and no buffer logic exists.

## Test plan
- Read, ack latency 3:
  - Stimulus: ReadEnable = 1, Address = 0x0000_1004, DBus_RData = 0xDEAD_BEEF.
  - Response: DBus_Req high with DBus_Addr = 0x0000401 and DBus_WE = 0000; DataMem_Ready one cycle after ack with MReadData = 0xDEAD_BEEF; a single pulse only, despite ReadEnable held during RESP.
- Byte write:
  - Stimulus: WriteEnable = 0100, MWriteData = 0x5A5A_5A5A, ack in cycle 1.
  - Response: DBus_WE = 0100, DBus_WData = 0x5A5A_5A5A; DataMem_Ready 2 cycles after the command.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, no ack.
  - Response: DBus_Req high exactly 4 cycles; DataMem_Ready and BusError pulse together; MReadData = 0.
  - Variant: ack on the 4th cycle -> no BusError.
- Async reset:
  - Stimulus: reset asserted mid-BUS.
  - Response: DBus_Req drops in the same cycle, no DataMem_Ready; a late ack is ignored and the next read completes normally.
- Posted write (macro on):
  - Stimulus: a write, then a read one cycle after its Ready.
  - Response: write Ready at latency 1; the read's DBus_Req is not raised until the write's DBus_Ack; read data correct.
- Macro off: the same sequence gives the write latency ≥ 2 and the bus order write then read.
